debounce_timer: RTL

//  - Timer that pairs with the button debounce FSM. It counts while timer_reset is low
//    and raises timer_done once the settle interval has elapsed.
//  - The FSM drives timer_reset high in its idle and held states, so timer_reset is a

---
 rtl/debounce_pkg.sv | 32 +++
 rtl/debounce_timer_tick_gen.sv | 34 +++
 rtl/debounce_timer.sv | 106 ++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debounce FSM and its settle timer.
package debounce_pkg;

  // One-hot state constants used by the button debounce FSM.
  localparam logic [3:0] S0 = 4'b0001;
  localparam logic [3:0] S1 = 4'b0010;
  localparam logic [3:0] S2 = 4'b0100;
  localparam logic [3:0] S3 = 4'b1000;

  // Settle timer states, held in a 2-bit register.
  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_DONE = 2'd2
  } timer_state_t;

  // Clocks per tick.
  function automatic int div_calc(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to hold 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_timer_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the wrap edge as a tick.
module tick_gen
  import debounce_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_cnt;

  // Tick is combinational so the timer sees it on the same edge the prescaler wraps.
  assign tick = en && (pre_cnt == LAST);

  // Prescaler counter: cleared while clr is held, wraps to 0 after LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (pre_cnt == LAST) pre_cnt <= '0;
      else                 pre_cnt <= pre_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/debounce_timer.sv
// Settle timer for the button debounce FSM. Counts ticks while timer_reset is low
// and raises a sticky timer_done once period_reg ticks have elapsed.
// Optional feature macro: DEBOUNCE_TIMER_PULSE_EN adds the one-cycle `expired` output.
//
// Handshake: there is no valid/ready pair here. timer_reset is a level hold/clear
// (high = idle and cleared), load_en is a single-cycle strobe sampled on posedge clk,
// and timer_done is a registered level that stays high until timer_reset or reset.
module debounce_timer
  import debounce_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1_000,
  parameter int PERIOD_TICKS = 20,
  parameter int TW           = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          timer_reset,
  output logic          timer_done,
  input  logic          load_en,
  input  logic [TW-1:0] load_val,
  output logic          busy
`ifdef DEBOUNCE_TIMER_PULSE_EN
  ,
  output logic          expired
`endif
);

  localparam int DIV = div_calc(CLK_HZ, TICK_HZ);
  localparam logic [TW-1:0] PERIOD_INIT =
    (PERIOD_TICKS == 0) ? TW'(1) : TW'(PERIOD_TICKS);

  timer_state_t  state, state_next;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] period_reg;
  logic          tick;
  logic          count_en;
  logic          reached;

  // The first low edge out of IDLE already counts as a prescaler step.
  assign count_en = !timer_reset && ((state == T_IDLE) || (state == T_RUN));

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_reset),
    .en    (count_en),
    .tick  (tick)
  );

  // Expiry: either a freshly loaded period is already met, or this tick reaches it.
  assign reached = (tick_cnt >= period_reg) ||
                   (tick && (({1'b0, tick_cnt} + 1'b1) >= {1'b0, period_reg}));

  // Next-state logic; timer_reset overrides everything, including a same-edge expiry.
  always_comb begin
    state_next = state;
    case (state)
      T_IDLE:  state_next = T_RUN;
      T_RUN:   if (reached) state_next = T_DONE;
      T_DONE:  state_next = T_DONE;
      default: state_next = T_IDLE;
    endcase
    if (timer_reset) state_next = T_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= T_IDLE;
    else        state <= state_next;
  end

  // Tick counter: cleared on hold, saturates at period_reg so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (timer_reset) begin
      tick_cnt <= '0;
    end else if (count_en && tick && (tick_cnt < period_reg)) begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Period register: loads in any state; a zero period is stored as one tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_reg <= PERIOD_INIT;
    end else if (load_en) begin
      period_reg <= (load_val == '0) ? TW'(1) : load_val;
    end
  end

  assign timer_done = (state == T_DONE);
  assign busy       = (state == T_RUN) && !timer_reset;

`ifdef DEBOUNCE_TIMER_PULSE_EN
  // One-cycle pulse registered on the edge where timer_done goes 0->1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) expired <= 1'b0;
    else        expired <= (state != T_DONE) && (state_next == T_DONE);
  end
`else
  // No pulse output in this build.
`endif

endmodule
